store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer between the processor data port and the single-port word-addressed data memory.
- Queues stores in a FIFO so the CPU does not wait on memory.
- Drains one store per cycle to memory whenever the port is not needed by a load.
- Loads read memory and take data from the youngest matching queued store, so the CPU always sees program-order memory.

Parameters:
DEPTH, 4, number of buffered stores (power of two, 2..16)
PTR_W, 2, log2(DEPTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
cpu_we  input  1  store request this cycle
cpu_re  input  1  load request this cycle (mutually exclusive with cpu_we; if both are high, cpu_we wins and the load is ignored)
cpu_addr  input  32  byte address; only [31:2] is used (word aligned)
cpu_wdata  input  32  store data
cpu_rdata  output  32  load data (combinational)
stall  output  1  CPU must hold its current request and retry next cycle
mem_we  output  1  write strobe to data memory
mem_addr  output  32  address to data memory
mem_wdata  output  32  write data to data memory
mem_rdata  input  32  combinational read data from memory
count  output  PTR_W+1  number of occupied entries

Behaviour:
- Storage: circular FIFO of DEPTH entries {waddr[29:0], data[31:0]}, with head (oldest) pointer, tail pointer and count.
- full = (count == DEPTH); empty = (count == 0).
- Reset (asynchronous): head = tail = count = 0. All pending stores are discarded, including during a drain. Outputs while reset is asserted and after release:
  - mem_we = 0, stall = 0, count = 0.
  - mem_addr = cpu_addr, cpu_rdata = mem_rdata.
- stall = full && (cpu_we || cpu_re). When full, draining has priority over new requests, which guarantees forward progress.
- Push: cpu_we && !full. Entry {cpu_addr[31:2], cpu_wdata} is written at tail on the rising edge; tail++ (wraps modulo DEPTH); count++.
- Drain, when !empty && (!cpu_re || full):
  - mem_we = 1, mem_addr = {head.waddr, 2'b00}, mem_wdata = head.data.
  - On the edge: head++ (wraps), count--.
- Load, when cpu_re && !full:
  - mem_we = 0, mem_addr = cpu_addr.
  - cpu_rdata = data of the youngest valid entry with waddr == cpu_addr[31:2]; otherwise mem_rdata.
  - Comparison is on all valid entries, scanning from tail-1 back toward head.
  - A load is zero latency: the result is valid in the same cycle.
- Idle (no load, empty): mem_we = 0, mem_addr = cpu_addr, mem_wdata = cpu_wdata.
- Push and drain in the same cycle (not full): both happen and count is unchanged. The drain writes the head entry, never the store being pushed in that cycle.
- Push while full: not accepted. stall = 1, the drain proceeds, and the CPU retries next cycle. No same-cycle bypass of a freed slot.
- Empty buffer with a store: the store is pushed, not written straight to memory. It reaches memory no earlier than the next cycle (1-cycle minimum write latency).
- Multiple stores to the same word: all are queued and drained in program order. Forwarding returns the youngest.
- Stores are never coalesced or reordered. Memory is written at most one word per cycle.
- Pointer wrap: head/tail roll from DEPTH-1 to 0. count distinguishes full from empty.

Test Plan:
- Reset then idle: count = 0, mem_we = 0, stall = 0. cpu_re at addr 0x10 with RAM[4] = 0xAAAA0000 -> cpu_rdata = 0xAAAA0000.
- Single store 0x10 <= 0x12345678 with no loads: count = 1 after edge 1. Next cycle mem_we = 1, mem_addr = 0x10, mem_wdata = 0x12345678. After that edge RAM[4] = 0x12345678 and count = 0.
- Forwarding: stores 0x20 <= 0x1, then 0x20 <= 0x2, then immediate load 0x20 every cycle -> cpu_rdata = 0x2 while queued (no drain while loading and not full); load 0x24 -> memory value.
- Full: 4 back-to-back stores with continuous loads -> count = 4. A 5th store sees stall = 1 for one cycle while the head drains (count 3). The 5th store is accepted on the retry. Final memory order matches program order.
- Simultaneous push and drain at count = 2 -> count stays 2. The drained entry is the oldest. Tail wraps 3 -> 0 across the sequence.
- Reset mid-drain with count = 3 -> count = 0 and mem_we = 0 immediately (async). The remaining stores never reach memory.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write buffer between the CPU data port and a single-port word memory.
// Stores queue in a circular FIFO and drain one per cycle when no load needs the port.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_we,
   input  logic             cpu_re,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic [31:0]      cpu_rdata,
   output logic             stall,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [29:0]      waddr_q [DEPTH];
   logic [31:0]      data_q  [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [PTR_W:0]   count_q;

   logic        full;
   logic        empty;
   logic        push;
   logic        drain;
   logic        load;
   logic        fwd_hit;
   logic [31:0] fwd_data;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   // CPU handshake: a request (cpu_we or cpu_re) completes in the cycle it is
   // presented unless stall is high, in which case the CPU holds it and retries.
   // A store that collides with a load request wins; the load is ignored, but a
   // raised cpu_re still holds the port so stores accumulate rather than drain.
   assign stall = full && (cpu_we || cpu_re);
   assign push  = cpu_we && !full;
   assign load  = cpu_re && !cpu_we && !full;
   assign drain = !empty && (!cpu_re || full);

   // Oldest-to-youngest scan so the last match seen is the youngest store.
   always_comb begin
      logic [PTR_W-1:0] idx;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (((PTR_W+1)'(i) < count_q) && (waddr_q[idx] == cpu_addr[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[idx];
         end
      end
   end

   assign cpu_rdata = (load && fwd_hit) ? fwd_data : mem_rdata;
   assign mem_we    = drain;
   assign mem_addr  = drain ? {waddr_q[head_q], 2'b00} : cpu_addr;
   assign mem_wdata = drain ? data_q[head_q] : cpu_wdata;
   assign count     = count_q;

   // Payload storage carries no reset; validity is defined by head/count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         waddr_q[tail_q] <= cpu_addr[31:2];
         data_q[tail_q]  <= cpu_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            tail_q <= tail_q + 1'b1;
         end
         if (drain) begin
            head_q <= head_q + 1'b1;
         end
         case ({push, drain})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: per-cycle vector table plus a reset-mid-drain
// sequence, with a memory model and an expected-write queue.
module tb_store_buffer;

   logic        clk;
   logic        reset;
   logic        cpu_we;
   logic        cpu_re;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        stall;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [2:0]  count;

   logic [31:0] ram [64];
   logic [63:0] exp_q [$];
   int          checks;
   int          errors;

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_stall;
      logic        exp_mwe;
      logic [31:0] exp_maddr;
      logic [31:0] exp_mwdata;
      logic [2:0]  exp_count;
   } vec_t;

   vec_t vecs [$];

   store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_we    (cpu_we),
      .cpu_re    (cpu_re),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .stall     (stall),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .count     (count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model and write scoreboard
   assign mem_rdata = ram[mem_addr[7:2]];

   always @(posedge clk) begin
      if (!reset && mem_we) begin
         ram[mem_addr[7:2]] <= mem_wdata;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mem_write_unexpected: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               errors++;
               $display("FAIL mem_write_order: got addr=%h data=%h, expected addr=%h data=%h",
                        mem_addr, mem_wdata, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic we, input logic re, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic chk_rd, input logic [31:0] exp_rd,
                          input logic exp_stall, input logic exp_mwe, input logic [31:0] exp_maddr,
                          input logic [31:0] exp_mwdata, input logic [2:0] exp_count);
      vec_t v;
      v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
      v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_stall = exp_stall;
      v.exp_mwe = exp_mwe; v.exp_maddr = exp_maddr; v.exp_mwdata = exp_mwdata;
      v.exp_count = exp_count;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wdata);
      cpu_we    = we;
      cpu_re    = re;
      cpu_addr  = addr;
      cpu_wdata = wdata;
   endtask

   task automatic run_vec(input int n, input vec_t v);
      drive(v.we, v.re, v.addr, v.wdata);
      @(negedge clk);
      chk($sformatf("v%0d_count", n), 32'(count), 32'(v.exp_count));
      chk($sformatf("v%0d_stall", n), 32'(stall), 32'(v.exp_stall));
      chk($sformatf("v%0d_mem_we", n), 32'(mem_we), 32'(v.exp_mwe));
      chk($sformatf("v%0d_mem_addr", n), mem_addr, v.exp_maddr);
      chk($sformatf("v%0d_mem_wdata", n), mem_wdata, v.exp_mwdata);
      if (v.chk_rd) chk($sformatf("v%0d_cpu_rdata", n), cpu_rdata, v.exp_rd);
      if (v.we && !v.exp_stall) exp_q.push_back({v.addr & 32'hFFFF_FFFC, v.wdata});
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 64; i++) ram[i] = 32'hBB00_0000 | 32'(i);
      ram[4] = 32'hAAAA_0000;
      reset = 1'b1;
      drive(1'b0, 1'b0, 32'h10, 32'h0);

      // we, re, addr, wdata, chk_rd, exp_rd, stall, mem_we, mem_addr, mem_wdata, count
      add_vec(0, 0, 32'h00, 32'h0,        0, 32'h0,        0, 0, 32'h00, 32'h0,        3'd0);
      add_vec(0, 1, 32'h10, 32'h0,        1, 32'hAAAA0000, 0, 0, 32'h10, 32'h0,        3'd0);
      add_vec(1, 0, 32'h10, 32'h12345678, 0, 32'h0,        0, 0, 32'h10, 32'h12345678, 3'd0);
      add_vec(0, 0, 32'h40, 32'h0,        0, 32'h0,        0, 1, 32'h10, 32'h12345678, 3'd1);
      add_vec(0, 1, 32'h10, 32'h0,        1, 32'h12345678, 0, 0, 32'h10, 32'h0,        3'd0);
      add_vec(1, 1, 32'h20, 32'h1,        0, 32'h0,        0, 0, 32'h20, 32'h1,        3'd0);
      add_vec(1, 1, 32'h20, 32'h2,        0, 32'h0,        0, 0, 32'h20, 32'h2,        3'd1);
      add_vec(0, 1, 32'h20, 32'h0,        1, 32'h2,        0, 0, 32'h20, 32'h0,        3'd2);
      add_vec(0, 1, 32'h24, 32'h0,        1, 32'hBB000009, 0, 0, 32'h24, 32'h0,        3'd2);
      add_vec(0, 0, 32'h00, 32'h0,        0, 32'h0,        0, 1, 32'h20, 32'h1,        3'd2);
      add_vec(0, 1, 32'h20, 32'h0,        1, 32'h2,        0, 0, 32'h20, 32'h0,        3'd1);
      add_vec(0, 0, 32'h00, 32'h0,        0, 32'h0,        0, 1, 32'h20, 32'h2,        3'd1);
      add_vec(0, 1, 32'h20, 32'h0,        1, 32'h2,        0, 0, 32'h20, 32'h0,        3'd0);
      add_vec(1, 1, 32'h30, 32'hD0,       0, 32'h0,        0, 0, 32'h30, 32'hD0,       3'd0);
      add_vec(1, 1, 32'h34, 32'hD1,       0, 32'h0,        0, 0, 32'h34, 32'hD1,       3'd1);
      add_vec(1, 1, 32'h38, 32'hD2,       0, 32'h0,        0, 0, 32'h38, 32'hD2,       3'd2);
      add_vec(1, 1, 32'h3C, 32'hD3,       0, 32'h0,        0, 0, 32'h3C, 32'hD3,       3'd3);
      add_vec(1, 1, 32'h40, 32'hE0,       0, 32'h0,        1, 1, 32'h30, 32'hD0,       3'd4);
      add_vec(1, 1, 32'h40, 32'hE0,       0, 32'h0,        0, 0, 32'h40, 32'hE0,       3'd3);
      add_vec(0, 1, 32'h3C, 32'h0,        0, 32'h0,        1, 1, 32'h34, 32'hD1,       3'd4);
      add_vec(0, 1, 32'h3C, 32'h0,        1, 32'hD3,       0, 0, 32'h3C, 32'h0,        3'd3);
      add_vec(0, 0, 32'h00, 32'h0,        0, 32'h0,        0, 1, 32'h38, 32'hD2,       3'd3);
      add_vec(1, 0, 32'h44, 32'hF0,       0, 32'h0,        0, 1, 32'h3C, 32'hD3,       3'd2);
      add_vec(1, 0, 32'h48, 32'hF1,       0, 32'h0,        0, 1, 32'h40, 32'hE0,       3'd2);
      add_vec(0, 0, 32'h00, 32'h0,        0, 32'h0,        0, 1, 32'h44, 32'hF0,       3'd2);
      add_vec(0, 0, 32'h00, 32'h0,        0, 32'h0,        0, 1, 32'h48, 32'hF1,       3'd1);
      add_vec(0, 0, 32'h00, 32'h0,        0, 32'h0,        0, 0, 32'h00, 32'h0,        3'd0);
      add_vec(1, 1, 32'h50, 32'hC0,       0, 32'h0,        0, 0, 32'h50, 32'hC0,       3'd0);
      add_vec(1, 1, 32'h54, 32'hC1,       0, 32'h0,        0, 0, 32'h54, 32'hC1,       3'd1);
      add_vec(1, 1, 32'h58, 32'hC2,       0, 32'h0,        0, 0, 32'h58, 32'hC2,       3'd2);

      // outputs while reset is held
      #2;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h10);
      chk("rst_cpu_rdata", cpu_rdata, 32'hAAAA0000);
      @(posedge clk);
      #1;
      reset = 1'b0;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // reset arriving mid-drain with three stores pending
      drive(1'b0, 1'b0, 32'h64, 32'h0);
      @(negedge clk);
      chk("mid_count", 32'(count), 32'd3);
      chk("mid_mem_we", 32'(mem_we), 32'd1);
      chk("mid_mem_addr", mem_addr, 32'h50);
      #1;
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_mem_we", 32'(mem_we), 32'd0);
      chk("async_stall", 32'(stall), 32'd0);
      chk("async_mem_addr", mem_addr, 32'h64);
      chk("async_cpu_rdata", cpu_rdata, 32'hBB000019);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst%0d_mem_we", i), 32'(mem_we), 32'd0);
         chk($sformatf("post_rst%0d_count", i), 32'(count), 32'd0);
         @(posedge clk);
         #1;
      end

      // final memory image reflects program order; discarded stores never landed
      chk("q_drained", 32'(exp_q.size()), 32'd0);
      chk("ram_10", ram[4], 32'h12345678);
      chk("ram_20", ram[8], 32'h2);
      chk("ram_30", ram[12], 32'hD0);
      chk("ram_34", ram[13], 32'hD1);
      chk("ram_38", ram[14], 32'hD2);
      chk("ram_3c", ram[15], 32'hD3);
      chk("ram_40", ram[16], 32'hE0);
      chk("ram_44", ram[17], 32'hF0);
      chk("ram_48", ram[18], 32'hF1);
      chk("ram_50", ram[20], 32'hBB000014);
      chk("ram_54", ram[21], 32'hBB000015);
      chk("ram_58", ram[22], 32'hBB000016);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
